// File: rtl/shared_adder_arb_if.sv
// Handshake bundle for shared_adder_arb: per-requester operand channel plus one tagged response channel.
interface shared_adder_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH:0]           rsp_sum;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/shared_adder_arb.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters, one registered tagged response.
// Optional SHARED_ADDER_ARB_SAT_EN: saturate the sum to WIDTH bits instead of exposing the carry.
module shared_adder_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  shared_adder_arb_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   rsp_id_p1;
  logic [WIDTH:0]    rsp_sum_p1;

  logic              can_accept;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  a_p0, b_p0;
  logic [WIDTH:0]    sum_p0;
  int                idx;

  function automatic logic [WIDTH:0] add_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef SHARED_ADDER_ARB_SAT_EN
    if (s[WIDTH]) s = {1'b0, {WIDTH{1'b1}}};
`endif
    return s;
  endfunction

  // Stage p0: arbitration and shared adder (combinational)
  always_comb begin
    can_accept = (state_q == IDLE) || bus.rsp_ready;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    // Nothing is offered while reset holds the block or the response slot is blocked.
    grant_vld = grant_vld && can_accept && !rst;
  end

  assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
  assign a_p0          = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign b_p0          = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign sum_p0        = add_sum(a_p0, b_p0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (grant_vld) begin
      state_d = HOLD;
      ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end else if (state_q == HOLD && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end

  // Stage p1: registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rsp_id_p1  <= '0;
      rsp_sum_p1 <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant_vld) begin
        rsp_id_p1  <= grant_idx;
        rsp_sum_p1 <= sum_p0;
      end
    end
  end

  assign bus.rsp_valid = (state_q == HOLD);
  assign bus.rsp_id    = rsp_id_p1;
  assign bus.rsp_sum   = rsp_sum_p1;

endmodule

// File: tb/tb_shared_adder_arb.sv
// Randomized and directed bench for shared_adder_arb against a transaction-level reference model.
module tb_shared_adder_arb;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shared_adder_arb_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus();
  shared_adder_arb #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model state: pending response slot and round-robin start point.
  int m_ptr;
  bit m_valid;
  int m_id;
  int m_sum;

  function automatic int ref_sum(input int a, input int b);
    int s;
    s = a + b;
`ifdef SHARED_ADDER_ARB_SAT_EN
    if (s > 65535) s = 65535;
`endif
    return s;
  endfunction

  function automatic int model_grant();
    int i;
    if (m_valid && !bus.rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    g = model_grant();
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[i]     = v;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_sum = 0;
  endtask

  // Advance one clock edge, updating the model from inputs seen before the edge.
  task automatic tick(output int g);
    int a, b;
    bit rr;
    g  = model_grant();
    rr = bus.rsp_ready;
    a  = (g >= 0) ? int'(bus.req_a[g*W +: W]) : 0;
    b  = (g >= 0) ? int'(bus.req_b[g*W +: W]) : 0;
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1; m_id = g; m_sum = ref_sum(a, b); m_ptr = (g + 1) % N;
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== '0) begin
      errors++; $display("FAIL reset_ready got %b want 0", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_sum !== '0) begin
      errors++; $display("FAIL reset_rsp got v=%b id=%0d sum=%h want 0/0/0", bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
    clear_reqs();
    rst = 1'b0;
    #1;
    tick(g);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle got v=%b want 0", bus.rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int g;
    do_reset();
    set_req(0, 1'b1, 16'h45, 16'h12);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready got %b want 0001", bus.req_ready);
    end
    tick(g);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 17'h00057) begin
      errors++; $display("FAIL single_rsp got v=%b id=%0d sum=%h want 1/0/00057", bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
    @(negedge clk);
    set_req(0, 1'b0, 16'h45, 16'h12);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL single_pulse got %b want 0000", bus.req_ready);
    end
    tick(g);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 17'h00057 || bus.rsp_id !== 2'd0) begin
      errors++; $display("FAIL single_drain got v=%b id=%0d sum=%h want 0/0/00057", bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(i), 16'd100);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== (N'(1) << (k % N))) begin
        errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, N'(1) << (k % N));
      end
      tick(g);
      checks++;
      if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != k % N || int'(bus.rsp_sum) != 100 + k % N) begin
        errors++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d sum=%0d want 1/%0d/%0d", k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, k % N, 100 + k % N);
      end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  task automatic test_backpressure();
    int g;
    do_reset();
    set_req(2, 1'b1, 16'd7, 16'd9);
    tick(g);
    @(negedge clk);
    set_req(2, 1'b0, 16'd7, 16'd9);
    set_req(1, 1'b1, 16'd1000, 16'd2000);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== '0) begin
        errors++; $display("FAIL bp_ready[%0d] got %b want 0", k, bus.req_ready);
      end
      tick(g);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_sum !== 17'd16) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d sum=%0d want 1/2/16", k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_release_ready got %b want 0010", bus.req_ready);
    end
    tick(g);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== 17'd3000) begin
      errors++; $display("FAIL bp_next got v=%b id=%0d sum=%0d want 1/1/3000", bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_overflow();
    int g;
    logic [W:0] want;
`ifdef SHARED_ADDER_ARB_SAT_EN
    want = 17'h0FFFF;
`else
    want = 17'h10000;
`endif
    do_reset();
    set_req(3, 1'b1, 16'hFFFF, 16'h0001);
    tick(g);
    checks++;
    if (bus.rsp_sum !== want || bus.rsp_id !== 2'd3) begin
      errors++; $display("FAIL overflow got id=%0d sum=%h want 3/%h", bus.rsp_id, bus.rsp_sum, want);
    end
    @(negedge clk);
    set_req(3, 1'b1, 16'hFFFF, 16'hFFFF);
    tick(g);
    checks++;
    if (int'(bus.rsp_sum) != ref_sum(65535, 65535)) begin
      errors++; $display("FAIL overflow_max got %h want %h", bus.rsp_sum, ref_sum(65535, 65535));
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_async_reset();
    int g;
    do_reset();
    bus.rsp_ready = 1'b0;
    set_req(2, 1'b1, 16'd5, 16'd6);
    tick(g);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0) begin
      errors++; $display("FAIL async_rst got v=%b sum=%h want 0/0", bus.rsp_valid, bus.rsp_sum);
    end
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL async_first_grant got %b want 0001", bus.req_ready);
    end
    tick(g);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin
      errors++; $display("FAIL async_first_rsp got v=%b id=%0d want 1/0", bus.rsp_valid, bus.rsp_id);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_pointer();
    int g;
    do_reset();
    set_req(1, 1'b1, 16'd10, 16'd1);
    set_req(3, 1'b1, 16'd30, 16'd3);
    tick(g);
    checks++;
    if (bus.rsp_id !== 2'd1) begin
      errors++; $display("FAIL ptr_first got %0d want 1", bus.rsp_id);
    end
    @(negedge clk);
    tick(g);
    checks++;
    if (bus.rsp_id !== 2'd3 || bus.rsp_sum !== 17'd33) begin
      errors++; $display("FAIL ptr_second got id=%0d sum=%0d want 3/33", bus.rsp_id, bus.rsp_sum);
    end
    @(negedge clk);
    set_req(0, 1'b1, 16'd40, 16'd2);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL ptr_wrap got %b want 0001", bus.req_ready);
    end
    tick(g);
    @(negedge clk);
    clear_reqs();
    set_req(2, 1'b1, 16'd2, 16'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin
        errors++; $display("FAIL ptr_lone[%0d] got %b want 0100", k, bus.req_ready);
      end
      tick(g);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_sum !== 17'd4) begin
        errors++; $display("FAIL ptr_lone_rsp[%0d] got v=%b id=%0d sum=%0d want 1/2/4", k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
      end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  task automatic test_random();
    int g;
    logic [W-1:0] ra;
    do_reset();
    g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || g == i) begin
          ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
          set_req(i, ($urandom_range(0, 9) < 6), ra, W'($urandom));
        end else if ($urandom_range(0, 9) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (bus.req_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready[%0d] got %b want %b", c, bus.req_ready, model_ready());
      end
      tick(g);
      checks++;
      if (bus.rsp_valid !== m_valid || int'(bus.rsp_id) != m_id || int'(bus.rsp_sum) != m_sum) begin
        errors++; $display("FAIL rand_rsp[%0d] got v=%b id=%0d sum=%0d want %b/%0d/%0d", c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, m_valid, m_id, m_sum);
      end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_async_reset();
    test_pointer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_adder_arb.md
Name: shared_adder_arb

Overview:
- Round-robin arbiter and sequencer sharing one 16-bit combinational adder (17-bit result) among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- Block grants one request per cycle, drives the shared adder, registers the sum, and returns it tagged with the requester ID on a single response channel with backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 16, operand width; sum width is WIDTH+1
ID_W, 2, requester-ID width, clog2(NUM_REQ)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_a  input  NUM_REQ*WIDTH  flattened operand A; requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  flattened operand B, same packing
rsp_valid  output  1  response holds a valid sum
rsp_ready  input  1  consumer accepts response
rsp_id  output  ID_W  index of requester that produced the sum
rsp_sum  output  WIDTH+1  registered sum, carry in MSB

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, round-robin pointer=0, state=IDLE. req_ready=0 while rst is high.
- States:
  - IDLE: no response held.
  - HOLD: rsp_valid=1, waiting for rsp_ready.
- can_accept = (state==IDLE) || (state==HOLD && rsp_ready).
- Arbitration (combinational):
  - When can_accept, grant the first asserted req_valid searching from pointer upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only.
  - Handshake completes when req_valid[g] && req_ready[g].
  - req_ready never asserts for an index whose req_valid is low.
- Datapath: the shared adder sees the granted requester's req_a/req_b. At the handshake edge, rsp_sum <= zero-extended A + B (WIDTH+1 bits, no truncation), rsp_id <= g, state <= HOLD, pointer <= (g+1) mod NUM_REQ.
- Latency: accept at edge N, rsp_valid high after edge N.
- Throughput: 1 op/cycle when rsp_ready is held high. Back-to-back accept in HOLD when rsp_ready=1.
- HOLD with rsp_ready=0:
  - rsp_sum and rsp_id stay stable.
  - All req_ready are 0.
  - Pointer is unchanged.
- HOLD with rsp_ready=1 and no req_valid: state <= IDLE, rsp_valid <= 0; rsp_sum/rsp_id retain their last values.
- Requesters must hold req_a/req_b stable while req_valid is high and not yet accepted.
- Dropping req_valid before acceptance is permitted; the block ignores it.
- Pointer advances only on an actual grant. A lone active requester is granted every available cycle.
- Wrap-around: grant at NUM_REQ-1 sets pointer to 0.
- Reset mid-operation: any held response is discarded immediately (rsp_valid=0 asynchronously). Pending requests are not accepted until after rst deasserts.

Optional Feature:
- Macro SHARED_ADDER_ARB_SAT_EN.
- Defined: sum saturates to WIDTH bits. If the carry is set, rsp_sum = {1'b0, all-ones WIDTH}; otherwise {1'b0, A+B}. rsp_sum MSB is always 0.
- Undefined: full WIDTH+1-bit sum with the carry in the MSB. Port widths are identical in both builds.

Test Plan:
- Single request:
  - Stimulus: req 0, A=16'h45, B=16'h12, rsp_ready=1.
  - Required: req_ready[0] pulses one cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=17'h00057 (87).
- All requesters, round-robin:
  - Stimulus: all four requesters valid continuously with A=i, B=100, rsp_ready=1.
  - Required: grants in order 0,1,2,3,0,1; rsp_sum 100,101,102,103,100,...; one response per cycle.
- Backpressure:
  - Stimulus: request from req 2, then rsp_ready=0 for 5 cycles.
  - Required: rsp_valid, rsp_id=2 and rsp_sum stay stable; req_ready=0 throughout; the accept that completes on the rsp_ready=1 cycle has its sum presented the following cycle.
- Overflow:
  - Stimulus: A=16'hFFFF, B=16'h0001.
  - Required: rsp_sum=17'h10000 without SHARED_ADDER_ARB_SAT_EN; 17'h0FFFF with it.
- Async reset:
  - Stimulus: assert rst mid-cycle while in HOLD.
  - Required: rsp_valid falls without waiting for clk; after release the first grant goes to requester 0.
- Pointer behaviour:
  - Stimulus: requesters 1 and 3 valid; after granting 3, requester 0 asserts.
  - Required: next grant is 0, not 1 (wrap from pointer 0); a lone valid requester is granted every cycle.
